// File: rtl/multi_filter_tap_accum.sv
// Tap accumulator for multi_filter: sums TAPS products, scales by >>SHIFT, saturates to OUT_W.
// Optional MULTI_FILTER_ROUND_EN selects round-half-up scaling instead of truncation.
//
// state | meaning
// ACCUM | accepting products, building the partial sum
// HOLD  | finished pixel presented on out_data until downstream takes it
module multi_filter_tap_accum #(
    parameter int TAPS   = 9,
    parameter int PROD_W = 17,
    parameter int SHIFT  = 4,
    parameter int OUT_W  = 8
) (
    input  logic              ap_clk,
    input  logic              ap_rst_n,
    input  logic              clr,
    input  logic [PROD_W-1:0] prod_data,
    input  logic              prod_valid,
    output logic              prod_ready,
    output logic [OUT_W-1:0]  out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [5:0]        tap_cnt
);

    localparam int ACC_W = PROD_W + $clog2(TAPS);
`ifdef MULTI_FILTER_ROUND_EN
    localparam int RND = (SHIFT == 0) ? 0 : (1 << (SHIFT - 1));
`endif

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t             state, state_nxt;
    logic [ACC_W-1:0]   acc, acc_nxt;
    logic [5:0]         tap_cnt_nxt;
    logic [OUT_W-1:0]   out_data_nxt;
    logic [ACC_W-1:0]   sum;
    logic [ACC_W:0]     scaled;
    logic [OUT_W-1:0]   pix;
    logic               accept;
    logic               final_tap;

    assign prod_ready = (state == ACCUM);
    assign out_valid  = (state == HOLD);
    assign accept     = prod_valid & prod_ready;
    assign final_tap  = (tap_cnt == 6'(TAPS - 1));
    assign sum        = acc + ACC_W'(prod_data);

    // One extra bit so the rounding add cannot wrap before saturation.
`ifdef MULTI_FILTER_ROUND_EN
    assign scaled = ({1'b0, sum} + (ACC_W + 1)'(RND)) >> SHIFT;
`else
    assign scaled = {1'b0, sum} >> SHIFT;
`endif

    assign pix = (scaled > (ACC_W + 1)'((2 ** OUT_W) - 1)) ? {OUT_W{1'b1}} : scaled[OUT_W-1:0];

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state    <= ACCUM;
            acc      <= '0;
            tap_cnt  <= '0;
            out_data <= '0;
        end else begin
            state    <= state_nxt;
            acc      <= acc_nxt;
            tap_cnt  <= tap_cnt_nxt;
            out_data <= out_data_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        acc_nxt      = acc;
        tap_cnt_nxt  = tap_cnt;
        out_data_nxt = out_data;
        if (clr) begin
            state_nxt   = ACCUM;
            acc_nxt     = '0;
            tap_cnt_nxt = '0;
        end else begin
            case (state)
                ACCUM: begin
                    if (accept) begin
                        if (final_tap) begin
                            out_data_nxt = pix;
                            acc_nxt      = '0;
                            tap_cnt_nxt  = '0;
                            state_nxt    = HOLD;
                        end else begin
                            acc_nxt     = sum;
                            tap_cnt_nxt = tap_cnt + 6'd1;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) state_nxt = ACCUM;
                end
                default: state_nxt = ACCUM;
            endcase
        end
    end

endmodule
